vga_sync_generator: RTL and testbench
=====================================

// Module: vga_sync_generator
// PURPOSE
//   Source of the pixel coordinate bus (hpos/vpos) consumed by every painter in the display path.
//   Free-running horizontal/vertical counters advance once per pixel strobe.
//   Generates registered hsync/vsync, display_on, and line/frame start strobes.
//   Sits between the pixel-clock enable and the painter/colour mux stage.
// PARAMETERS
//   H_DISPLAY  640  visible pixels per line
//   H_FRONT    16   horizontal front porch (pixels)
//   H_SYNC     96   hsync pulse width (pixels)
//   H_BACK     48   horizontal back porch (pixels); H_TOTAL = sum of the four H_* values = 800
//   V_DISPLAY  480  visible lines per frame
//   V_FRONT    10   vertical front porch (lines)
//   V_SYNC     2    vsync pulse width (lines)
//   V_BACK     33   vertical back porch (lines); V_TOTAL = sum of the four V_* values = 525
//   SYNC_POL   0    active level of hsync/vsync (0 = active-low)
// PORTS
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   pix_en       in   1   pixel strobe; counters and all registered outputs update only when 1
//   hpos         out  10  horizontal pixel coordinate, 0..H_DISPLAY-1; forced 0 when display_on=0
//   vpos         out  9   vertical pixel coordinate, 0..V_DISPLAY-1; forced 0 when display_on=0
//   display_on   out  1   1 while (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY)
//   hsync        out  1   horizontal sync, SYNC_POL-active
//   vsync        out  1   vertical sync, SYNC_POL-active
//   line_start   out  1   single-clk pulse when the counters enter h_cnt=0 (every line, blanked lines included)
//   frame_start  out  1   single-clk pulse when the counters enter (0,0)
// BEHAVIOUR
//   - Internal counters: h_cnt 10b, 0..H_TOTAL-1; v_cnt 10b, 0..V_TOTAL-1. Only vpos is truncated to 9b.
//   - All outputs are registers; no combinational path from pix_en to any output.
//   - On clk with pix_en=1:
//     - h_cnt wraps H_TOTAL-1 -> 0.
//     - v_cnt increments only on h wrap, and wraps V_TOTAL-1 -> 0.
//     - Outputs are computed from the NEW counter values, so every output is aligned to the same pixel.
//   - hsync active iff H_DISPLAY+H_FRONT <= h_cnt < H_DISPLAY+H_FRONT+H_SYNC (656..751 at defaults).
//   - vsync active iff V_DISPLAY+V_FRONT <= v_cnt < V_DISPLAY+V_FRONT+V_SYNC (490..491 at defaults).
//     - vsync transitions coincide with h_cnt=0.
//   - pix_en=0: counters, hpos, vpos, display_on, hsync and vsync all hold.
//     - line_start and frame_start go 0 on the next clk.
//   - Strobes:
//     - line_start=1 exactly one clk, the clk after the pix_en edge that loaded h_cnt=0.
//     - frame_start=1 in that same clk when v_cnt also became 0.
//   - Reset (asynchronous, any time, including mid-line/mid-frame):
//     - Counters go to h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 (last blanked pixel of the frame).
//     - hpos=0, vpos=0, display_on=0.
//     - hsync=vsync=~SYNC_POL (inactive).
//     - line_start=0, frame_start=0.
//   - First pix_en after rst_n deassertion loads (0,0):
//     - display_on=1, hpos=0, vpos=0.
//     - line_start=frame_start=1 for one clk.
//   - No state machine beyond the two counters.
//   - Parameters are not range-checked; the H_* sum must fit 10b and the V_* sum must fit 10b.
// TESTING
//   - Reset then pix_en held 1: after 1st clk -> hpos=0, vpos=0, display_on=1, frame_start=1, line_start=1. After 2nd clk -> both strobes 0, hpos=1.
//   - Run to h_cnt=639 then one more pix_en -> display_on=0, hpos=0. hsync (active-low) drops at h_cnt=656 and rises at h_cnt=752. Exactly 96 pixel strobes low.
//   - Full frame with pix_en every clk -> frame_start period 420000 clks. line_start period 800 clks. vsync low for exactly 1600 clks, starting at v_cnt=490, h_cnt=0.
//   - pix_en=1 every 4th clk -> same sequence per strobe. Outputs stable between strobes. Each strobe pulse lasts exactly 1 clk.
//   - Assert rst_n=0 at h_cnt=300, v_cnt=200 -> outputs reach reset values without a clk edge. After release, first pix_en gives (0,0) with frame_start=1.
//   - SYNC_POL=1 build -> hsync/vsync idle low and high during the same 656..751 / 490..491 windows.

Source files
------------

// File: rtl/vga_sync_if.sv
// Pixel-coordinate and timing bus from the sync generator to the painter/colour-mux stage.
// The generator drives every signal; painters only observe them.
interface vga_sync_if;
    logic [9:0] hpos;
    logic [8:0] vpos;
    logic       display_on;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;

    modport master (
        output hpos,
        output vpos,
        output display_on,
        output hsync,
        output vsync,
        output line_start,
        output frame_start
    );

    modport slave (
        input hpos,
        input vpos,
        input display_on,
        input hsync,
        input vsync,
        input line_start,
        input frame_start
    );
endinterface

// File: rtl/vga_sync_generator.sv
// Free-running VGA horizontal/vertical timing generator advancing once per pixel strobe.
// Every output is registered and derived from the post-increment counter values.
module vga_sync_generator #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    vga_sync_if.master vga
);
    localparam logic [9:0] H_LAST     = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST     = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [9:0] h_cnt_r;
    logic [9:0] v_cnt_r;
    logic [9:0] hpos_r;
    logic [8:0] vpos_r;
    logic       display_on_r;
    logic       hsync_r;
    logic       vsync_r;
    logic       line_start_r;
    logic       frame_start_r;

    logic       h_wrap_s;
    logic [9:0] h_next_s;
    logic [9:0] v_next_s;
    logic       display_next_s;
    logic [9:0] hpos_next_s;
    logic [8:0] vpos_next_s;
    logic       hsync_next_s;
    logic       vsync_next_s;
    logic       line_start_next_s;
    logic       frame_start_next_s;

    // Next counter values and the outputs they imply, so all outputs align to one pixel.
    always_comb begin
        h_wrap_s = (h_cnt_r == H_LAST);
        if (h_wrap_s) begin
            h_next_s = 10'd0;
        end else begin
            h_next_s = h_cnt_r + 10'd1;
        end
        if (h_wrap_s) begin
            if (v_cnt_r == V_LAST) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = v_cnt_r + 10'd1;
            end
        end else begin
            v_next_s = v_cnt_r;
        end

        display_next_s = (h_next_s < H_VIS) && (v_next_s < V_VIS);
        if (display_next_s) begin
            hpos_next_s = h_next_s;
            vpos_next_s = v_next_s[8:0];
        end else begin
            hpos_next_s = 10'd0;
            vpos_next_s = 9'd0;
        end

        if ((h_next_s >= HS_START) && (h_next_s < HS_END)) begin
            hsync_next_s = SYNC_POL;
        end else begin
            hsync_next_s = ~SYNC_POL;
        end
        // vsync keys off v only, so its edges naturally land on h_cnt=0
        if ((v_next_s >= VS_START) && (v_next_s < VS_END)) begin
            vsync_next_s = SYNC_POL;
        end else begin
            vsync_next_s = ~SYNC_POL;
        end

        line_start_next_s  = (h_next_s == 10'd0);
        frame_start_next_s = (h_next_s == 10'd0) && (v_next_s == 10'd0);
    end

    // Counter and output registers; reset parks on the last blanked pixel so the first strobe lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r       <= H_LAST;
            v_cnt_r       <= V_LAST;
            hpos_r        <= 10'd0;
            vpos_r        <= 9'd0;
            display_on_r  <= 1'b0;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (pix_en) begin
            h_cnt_r       <= h_next_s;
            v_cnt_r       <= v_next_s;
            hpos_r        <= hpos_next_s;
            vpos_r        <= vpos_next_s;
            display_on_r  <= display_next_s;
            hsync_r       <= hsync_next_s;
            vsync_r       <= vsync_next_s;
            line_start_r  <= line_start_next_s;
            frame_start_r <= frame_start_next_s;
        end else begin
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

    assign vga.hpos        = hpos_r;
    assign vga.vpos        = vpos_r;
    assign vga.display_on  = display_on_r;
    assign vga.hsync       = hsync_r;
    assign vga.vsync       = vsync_r;
    assign vga.line_start  = line_start_r;
    assign vga.frame_start = frame_start_r;
endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: a default-timing instance plus a tiny SYNC_POL=1 instance
// so whole frames fit in a short run; expected outputs come from a per-instance timing model.
module tb_vga_sync_generator;
    typedef struct packed {
        logic [9:0] hpos;
        logic [8:0] vpos;
        logic       disp;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } out_t;

    typedef struct {
        logic       en;
        logic [9:0] hpos;
        logic [8:0] vpos;
        logic       disp;
        logic       ls;
        logic       fs;
    } vec_t;

    // Small instance geometry: 15 clocks per line, 9 lines, 135 clocks per frame
    localparam int BHD = 8, BHF = 2, BHS = 3, BHB = 2;
    localparam int BVD = 4, BVF = 1, BVS = 2, BVB = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_en;

    vga_sync_if vif_a();
    vga_sync_if vif_b();

    vga_sync_generator dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (pix_en),
        .vga    (vif_a)
    );

    vga_sync_generator #(
        .H_DISPLAY(BHD), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_DISPLAY(BVD), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
        .SYNC_POL(1'b1)
    ) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (pix_en),
        .vga    (vif_b)
    );

    always #5 clk = ~clk;

    out_t act_a, act_b;
    assign act_a = {vif_a.hpos, vif_a.vpos, vif_a.display_on, vif_a.hsync, vif_a.vsync,
                    vif_a.line_start, vif_a.frame_start};
    assign act_b = {vif_b.hpos, vif_b.vpos, vif_b.display_on, vif_b.hsync, vif_b.vsync,
                    vif_b.line_start, vif_b.frame_start};

    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   m_ha, m_va, m_hb, m_vb;
    out_t exp_a, exp_b;
    out_t q_a[$];
    out_t q_b[$];
    vec_t tab_q[$];
    vec_t tab[6];

    bit   dense;
    int   last_ls_a, last_fs_b;
    int   hs_cnt_a, vs_cnt_b;
    bit   hs_arm_a, vs_arm_b;
    logic prev_hs_a, prev_vs_b;

    function automatic out_t calc(int h, int v, int hd, int hf, int hsw, int vd, int vf, int vsw,
                                  logic pol, logic ls, logic fs);
        out_t o;
        o.disp = (h < hd) && (v < vd);
        o.hpos = o.disp ? 10'(h) : 10'd0;
        o.vpos = o.disp ? 9'(v) : 9'd0;
        o.hs   = ((h >= hd + hf) && (h < hd + hf + hsw)) ? pol : ~pol;
        o.vs   = ((v >= vd + vf) && (v < vd + vf + vsw)) ? pol : ~pol;
        o.ls   = ls;
        o.fs   = fs;
        return o;
    endfunction

    task automatic cmp(input string name, input out_t act, input out_t exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got hpos=%0d vpos=%0d disp=%b hs=%b vs=%b ls=%b fs=%b, want hpos=%0d vpos=%0d disp=%b hs=%b vs=%b ls=%b fs=%b",
                     name, cyc, act.hpos, act.vpos, act.disp, act.hs, act.vs, act.ls, act.fs,
                     exp.hpos, exp.vpos, exp.disp, exp.hs, exp.vs, exp.ls, exp.fs);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear_trackers();
        last_ls_a = -1;
        last_fs_b = -1;
        hs_cnt_a  = 0;
        vs_cnt_b  = 0;
        hs_arm_a  = 1'b0;
        vs_arm_b  = 1'b0;
        prev_hs_a = act_a.hs;
        prev_vs_b = act_b.vs;
    endtask

    task automatic reset_models();
        m_ha  = 799;
        m_va  = 524;
        m_hb  = BHD + BHF + BHS + BHB - 1;
        m_vb  = BVD + BVF + BVS + BVB - 1;
        exp_a = '{hpos: 10'd0, vpos: 9'd0, disp: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0};
        exp_b = '{hpos: 10'd0, vpos: 9'd0, disp: 1'b0, hs: 1'b0, vs: 1'b0, ls: 1'b0, fs: 1'b0};
    endtask

    // One clock: drive pix_en, queue the model's prediction, then pop and compare after the edge
    task automatic step(input logic en);
        out_t ea, eb;
        pix_en = en;
        if (en) begin
            m_ha = (m_ha == 799) ? 0 : m_ha + 1;
            if (m_ha == 0) m_va = (m_va == 524) ? 0 : m_va + 1;
            exp_a = calc(m_ha, m_va, 640, 16, 96, 480, 10, 2, 1'b0,
                         m_ha == 0, (m_ha == 0) && (m_va == 0));
            m_hb = (m_hb == BHD + BHF + BHS + BHB - 1) ? 0 : m_hb + 1;
            if (m_hb == 0) m_vb = (m_vb == BVD + BVF + BVS + BVB - 1) ? 0 : m_vb + 1;
            exp_b = calc(m_hb, m_vb, BHD, BHF, BHS, BVD, BVF, BVS, 1'b1,
                         m_hb == 0, (m_hb == 0) && (m_vb == 0));
        end else begin
            exp_a.ls = 1'b0; exp_a.fs = 1'b0;
            exp_b.ls = 1'b0; exp_b.fs = 1'b0;
        end
        q_a.push_back(exp_a);
        q_b.push_back(exp_b);
        @(posedge clk);
        #1;
        cyc++;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        cmp("dut_a", act_a, ea);
        cmp("dut_b", act_b, eb);

        if (act_b.vs !== prev_vs_b) chk_int("vsync_edge_on_line_start_b", int'(act_b.ls), 1);
        if (dense) begin
            if (act_a.ls) begin
                if (last_ls_a >= 0) chk_int("line_start_period_a", cyc - last_ls_a, 800);
                last_ls_a = cyc;
            end
            if (act_b.fs) begin
                if (last_fs_b >= 0) chk_int("frame_start_period_b", cyc - last_fs_b, 135);
                last_fs_b = cyc;
            end
            if (prev_hs_a === 1'b1 && act_a.hs === 1'b0) begin
                hs_arm_a = 1'b1; hs_cnt_a = 1;
            end else if (hs_arm_a && act_a.hs === 1'b0) begin
                hs_cnt_a++;
            end else if (hs_arm_a) begin
                chk_int("hsync_low_width_a", hs_cnt_a, 96);
                hs_arm_a = 1'b0;
            end
            if (prev_vs_b === 1'b0 && act_b.vs === 1'b1) begin
                vs_arm_b = 1'b1; vs_cnt_b = 1;
            end else if (vs_arm_b && act_b.vs === 1'b1) begin
                vs_cnt_b++;
            end else if (vs_arm_b) begin
                chk_int("vsync_high_width_b", vs_cnt_b, 30);
                vs_arm_b = 1'b0;
            end
        end
        prev_hs_a = act_a.hs;
        prev_vs_b = act_b.vs;
    endtask

    initial begin
        vec_t tv;
        int   guard;
        rst_n  = 1'b0;
        pix_en = 1'b0;
        dense  = 1'b0;
        reset_models();

        // After-reset table for the default instance: first strobes, a hold gap, then counting on
        tab[0] = '{1'b1, 10'd0, 9'd0, 1'b1, 1'b1, 1'b1};
        tab[1] = '{1'b1, 10'd1, 9'd0, 1'b1, 1'b0, 1'b0};
        tab[2] = '{1'b0, 10'd1, 9'd0, 1'b1, 1'b0, 1'b0};
        tab[3] = '{1'b0, 10'd1, 9'd0, 1'b1, 1'b0, 1'b0};
        tab[4] = '{1'b1, 10'd2, 9'd0, 1'b1, 1'b0, 1'b0};
        tab[5] = '{1'b1, 10'd3, 9'd0, 1'b1, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        cmp("reset_a", act_a, exp_a);
        cmp("reset_b", act_b, exp_b);
        rst_n = 1'b1;
        clear_trackers();

        for (int i = 0; i < 6; i++) begin
            tab_q.push_back(tab[i]);
            step(tab[i].en);
            tv = tab_q.pop_front();
            chk_int("tab_hpos", int'(act_a.hpos), int'(tv.hpos));
            chk_int("tab_vpos", int'(act_a.vpos), int'(tv.vpos));
            chk_int("tab_disp", int'(act_a.disp), int'(tv.disp));
            chk_int("tab_line_start", int'(act_a.ls), int'(tv.ls));
            chk_int("tab_frame_start", int'(act_a.fs), int'(tv.fs));
        end

        // Every-clock strobes: display edge at 640, hsync window, line wrap, small-frame wraps
        dense = 1'b1;
        clear_trackers();
        repeat (1000) step(1'b1);

        // One strobe every 4th clock: same per-strobe sequence, held outputs between strobes
        dense = 1'b0;
        repeat (1000) begin
            step(1'b1);
            repeat (3) step(1'b0);
        end

        // Run to h_cnt=300 and reset asynchronously between clock edges
        dense = 1'b1;
        clear_trackers();
        guard = 0;
        while (m_ha != 300 && guard < 2000) begin
            step(1'b1);
            guard++;
        end
        chk_int("reach_h300_within_bound", int'(m_ha == 300), 1);
        #3;
        rst_n = 1'b0;
        #1;
        reset_models();
        cmp("async_reset_a", act_a, exp_a);
        cmp("async_reset_b", act_b, exp_b);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_trackers();
        step(1'b0);
        step(1'b1);
        chk_int("post_reset_frame_start_a", int'(act_a.fs), 1);
        chk_int("post_reset_display_on_a", int'(act_a.disp), 1);
        repeat (400) step(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
